// File: rtl/data_read_capture_ctrl_if.sv
// Command, sample-stream and buffer-write signals of the data_read capture controller.
// The controller uses the slave modport; whoever issues commands and samples uses master.
interface data_read_capture_ctrl_if;
  logic        cr_start;
  logic        cr_abort;
  logic        trig;
  logic [31:0] din;
  logic        din_valid;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sr_c;
  logic        busy;

  modport master (
    output cr_start, cr_abort, trig, din, din_valid,
    input  wr_en, wr_sel, wr_addr, wr_data, sr_c, busy
  );

  modport slave (
    input  cr_start, cr_abort, trig, din, din_valid,
    output wr_en, wr_sel, wr_addr, wr_data, sr_c, busy
  );
endinterface

// File: rtl/data_read_capture_ctrl.sv
// Write-side sequencer that fills sample buffers 0..BUF_COUNT-1 and then raises SR.C.
// Defining DATA_READ_TRIGGER_EN adds an ARM state that waits for a rising edge on trig.
module data_read_capture_ctrl #(
  parameter int BUF_COUNT = 4
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  data_read_capture_ctrl_if.slave bus
);

  localparam logic [1:0] LAST_SEL  = 2'(BUF_COUNT - 1);
  localparam logic [9:0] LAST_ADDR = 10'd1023;

`ifdef DATA_READ_TRIGGER_EN
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;
`endif

  state_e      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [1:0]  sel_q, sel_d;
  logic        sr_c_q, sr_c_d;
  logic        wr_en_q, wr_en_d;
  logic [1:0]  wr_sel_q, wr_sel_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        do_write;

`ifdef DATA_READ_TRIGGER_EN
  logic trig_q;
  logic trig_rise;

  assign trig_rise = bus.trig && !trig_q;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= bus.trig;
    end
  end
`else
  logic unused_trig;
  assign unused_trig = bus.trig;
`endif

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sel_q     <= '0;
      sr_c_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      sr_c_q    <= sr_c_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Abort overrides everything, including a start or a sample in the same cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    sr_c_d    = sr_c_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    do_write  = 1'b0;

    if (bus.cr_abort) begin
      state_d = IDLE;
      sr_c_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            sr_c_d = 1'b1;
          end
          if (bus.cr_start) begin
            sr_c_d = 1'b0;
            addr_d = '0;
            sel_d  = '0;
`ifdef DATA_READ_TRIGGER_EN
            state_d = ARM;
`else
            state_d = CAPTURE;
`endif
          end
        end
`ifdef DATA_READ_TRIGGER_EN
        ARM: begin
          if (trig_rise) begin
            state_d  = CAPTURE;
            do_write = bus.din_valid;
          end
        end
`endif
        CAPTURE: begin
          do_write = bus.din_valid;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (do_write) begin
        wr_en_d   = 1'b1;
        wr_sel_d  = sel_q;
        wr_addr_d = addr_q;
        wr_data_d = bus.din;
        addr_d    = addr_q + 10'd1;
        if (addr_q == LAST_ADDR) begin
          sel_d = sel_q + 2'd1;
          if (sel_q == LAST_SEL) begin
            state_d = DONE;
          end
        end
      end
    end
  end

  // The final write is still on the bus during the first DONE cycle, so busy covers it.
  assign bus.busy = (state_q == CAPTURE)
`ifdef DATA_READ_TRIGGER_EN
                  || (state_q == ARM)
`endif
                  || ((state_q == DONE) && wr_en_q);

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_sel  = wr_sel_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.sr_c    = sr_c_q;

endmodule

// File: tb/tb_data_read_capture_ctrl.sv
// Self-checking bench for data_read_capture_ctrl: unit A has BUF_COUNT=4, unit B has BUF_COUNT=1.
// A word-count model predicts every output each cycle; literal checks pin key moments.
module tb_data_read_capture_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_CAP  = 2;
  localparam int M_DONE = 3;

`ifdef DATA_READ_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  typedef struct {
    int          mode;
    int          count;
    bit          wrEn;
    int          wrSel;
    int          wrAddr;
    logic [31:0] wrData;
    bit          srC;
    bit          trigPrev;
  } modelT;

  logic        clk;
  logic        rst;
  logic [1:0]  startV;
  logic [1:0]  abortV;
  logic [1:0]  validV;
  logic        trigV;
  logic [31:0] dinV [2];

  int total = 0;
  int bad   = 0;
  int wcA   = 0;
  int wcB   = 0;
  int baseA;
  int baseB;
  logic [9:0] lastAddrB = '0;
  bit anySelB = 1'b0;

  modelT mA;
  modelT mB;

  data_read_capture_ctrl_if ifA ();
  data_read_capture_ctrl_if ifB ();

  assign ifA.cr_start  = startV[0];
  assign ifA.cr_abort  = abortV[0];
  assign ifA.din_valid = validV[0];
  assign ifA.din       = dinV[0];
  assign ifA.trig      = trigV;
  assign ifB.cr_start  = startV[1];
  assign ifB.cr_abort  = abortV[1];
  assign ifB.din_valid = validV[1];
  assign ifB.din       = dinV[1];
  assign ifB.trig      = trigV;

  data_read_capture_ctrl #(.BUF_COUNT(4)) dutA (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .bus          (ifA)
  );

  data_read_capture_ctrl #(.BUF_COUNT(1)) dutB (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .bus          (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic modelT modelReset();
    modelT r;
    r.mode     = M_IDLE;
    r.count    = 0;
    r.wrEn     = 1'b0;
    r.wrSel    = 0;
    r.wrAddr   = 0;
    r.wrData   = '0;
    r.srC      = 1'b0;
    r.trigPrev = 1'b0;
    return r;
  endfunction

  // One clock edge of the capture: sample number count lands at buffer count/1024, word count%1024.
  function automatic modelT modelStep(modelT m, int words, bit start, bit abort, bit trig,
                                      bit valid, logic [31:0] d);
    modelT n;
    bit rise;
    n = m;
    rise = trig && !m.trigPrev;
    n.trigPrev = trig;
    n.wrEn = 1'b0;
    if (abort) begin
      n.mode = M_IDLE;
      n.srC  = 1'b0;
    end else if ((m.mode == M_IDLE || m.mode == M_DONE) && start) begin
      n.mode  = TRIG_EN ? M_ARM : M_CAP;
      n.count = 0;
      n.srC   = 1'b0;
    end else begin
      if (m.mode == M_DONE) n.srC = 1'b1;
      if (m.mode == M_ARM && rise) n.mode = M_CAP;
      if (n.mode == M_CAP && valid) begin
        n.wrEn   = 1'b1;
        n.wrSel  = m.count / 1024;
        n.wrAddr = m.count % 1024;
        n.wrData = d;
        n.count  = m.count + 1;
        if (n.count == words) n.mode = M_DONE;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mA = modelReset();
      mB = modelReset();
    end else begin
      mA = modelStep(mA, 4096, startV[0], abortV[0], trigV, validV[0], dinV[0]);
      mB = modelStep(mB, 1024, startV[1], abortV[1], trigV, validV[1], dinV[1]);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareUnit(input string tag, input modelT m, input logic en, input logic [1:0] sel,
                             input logic [9:0] addr, input logic [31:0] data, input logic src,
                             input logic bsy);
    bit busyExp;
    busyExp = (m.mode == M_ARM) || (m.mode == M_CAP) || (m.mode == M_DONE && !m.srC);
    checkOutput({tag, ".wr_en"}, 32'(en), 32'(m.wrEn));
    if (m.wrEn) begin
      checkOutput({tag, ".wr_sel"}, 32'(sel), 32'(m.wrSel));
      checkOutput({tag, ".wr_addr"}, 32'(addr), 32'(m.wrAddr));
      checkOutput({tag, ".wr_data"}, data, m.wrData);
    end
    checkOutput({tag, ".sr_c"}, 32'(src), 32'(m.srC));
    checkOutput({tag, ".busy"}, 32'(bsy), 32'(busyExp));
  endtask

  always @(negedge clk) begin
    compareUnit("A", mA, ifA.wr_en, ifA.wr_sel, ifA.wr_addr, ifA.wr_data, ifA.sr_c, ifA.busy);
    compareUnit("B", mB, ifB.wr_en, ifB.wr_sel, ifB.wr_addr, ifB.wr_data, ifB.sr_c, ifB.busy);
    if (ifA.wr_en === 1'b1) wcA++;
    if (ifB.wr_en === 1'b1) begin
      wcB++;
      lastAddrB = ifB.wr_addr;
      if (ifB.wr_sel !== 2'd0) anySelB = 1'b1;
    end
  end

  task automatic applyStimulus(input int u, input bit start, input bit abort, input bit valid,
                               input bit trig, input logic [31:0] d);
    @(negedge clk);
    startV  = '0;
    abortV  = '0;
    validV  = '0;
    startV[u] = start;
    abortV[u] = abort;
    validV[u] = valid;
    trigV   = trig;
    dinV[u] = d;
  endtask

  task automatic checkFirstWriteA(input string tag);
    checkOutput({tag, ".first.wr_en"}, 32'(ifA.wr_en), 32'd1);
    checkOutput({tag, ".first.wr_sel"}, 32'(ifA.wr_sel), 32'd0);
    checkOutput({tag, ".first.wr_addr"}, 32'(ifA.wr_addr), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    startV = '0;
    abortV = '0;
    validV = '0;
    trigV  = 1'b0;
    dinV[0] = '0;
    dinV[1] = '0;
    repeat (3) @(negedge clk);
    checkOutput("A.reset.wr_en", 32'(ifA.wr_en), 32'd0);
    checkOutput("A.reset.sr_c", 32'(ifA.sr_c), 32'd0);
    checkOutput("A.reset.busy", 32'(ifA.busy), 32'd0);
    checkOutput("B.reset.wr_addr", 32'(ifB.wr_addr), 32'd0);
    rst = 1'b0;

    $display("[TB] reset in the middle of a capture");
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i <= 300; i++) applyStimulus(0, 0, 0, 1, 1, 32'(i));
    #2;
    rst = 1'b1;
    validV = '0;
    trigV  = 1'b0;
    #1;
    checkOutput("A.midrst.wr_en", 32'(ifA.wr_en), 32'd0);
    checkOutput("A.midrst.wr_sel", 32'(ifA.wr_sel), 32'd0);
    checkOutput("A.midrst.wr_addr", 32'(ifA.wr_addr), 32'd0);
    checkOutput("A.midrst.wr_data", ifA.wr_data, 32'd0);
    checkOutput("A.midrst.sr_c", 32'(ifA.sr_c), 32'd0);
    checkOutput("A.midrst.busy", 32'(ifA.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] full BUF_COUNT=4 capture");
    applyStimulus(0, 1, 0, 0, 0, 0);
    baseA = wcA;
    for (int i = 0; i < 4096; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 32'(i));
      if (i == 1) checkFirstWriteA("A.full");
    end
    applyStimulus(0, 0, 0, 1, 1, 32'd4096);
    checkOutput("A.full.last.wr_sel", 32'(ifA.wr_sel), 32'd3);
    checkOutput("A.full.last.wr_addr", 32'(ifA.wr_addr), 32'd1023);
    checkOutput("A.full.last.wr_data", ifA.wr_data, 32'd4095);
    checkOutput("A.full.last.sr_c", 32'(ifA.sr_c), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("A.full.done.sr_c", 32'(ifA.sr_c), 32'd1);
    checkOutput("A.full.done.wr_en", 32'(ifA.wr_en), 32'd0);
    checkOutput("A.full.done.busy", 32'(ifA.busy), 32'd0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("A.full.count", 32'(wcA - baseA), 32'd4096);

    $display("[TB] restart from DONE, start during capture, abort at word 1500");
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("A.restart.sr_c", 32'(ifA.sr_c), 32'd0);
    checkOutput("A.restart.busy", 32'(ifA.busy), 32'd1);
    baseA = wcA;
    for (int i = 0; i <= 1520; i++) begin
      applyStimulus(0, (i == 5 || i == 700), (i == 1500), 1, 1, 32'(i));
      if (i == 1) checkFirstWriteA("A.restart");
    end
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("A.abort.count", 32'(wcA - baseA), 32'd1500);
    checkOutput("A.abort.sr_c", 32'(ifA.sr_c), 32'd0);
    checkOutput("A.abort.busy", 32'(ifA.busy), 32'd0);

    $display("[TB] start and abort together");
    baseA = wcA;
    applyStimulus(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1, 32'(i));
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("A.startabort.count", 32'(wcA - baseA), 32'd0);
    checkOutput("A.startabort.busy", 32'(ifA.busy), 32'd0);

    $display("[TB] gapped BUF_COUNT=1 capture");
    applyStimulus(1, 1, 0, 0, 0, 0);
    baseB = wcB;
    for (int c = 0; c < 2048; c++) applyStimulus(1, 0, 0, (c % 2 == 0), 1, 32'(c / 2));
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("B.gap.sr_c", 32'(ifB.sr_c), 32'd1);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("B.gap.count", 32'(wcB - baseB), 32'd1024);
    checkOutput("B.gap.last_addr", 32'(lastAddrB), 32'd1023);
    checkOutput("B.gap.sel_nonzero", 32'(anySelB), 32'd0);

`ifdef DATA_READ_TRIGGER_EN
    $display("[TB] trigger held high while arming");
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 0);
    baseA = wcA;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1, 32'(100 + i));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 32'(200 + i));
    applyStimulus(0, 0, 0, 1, 1, 32'h0000_0abc);
    checkOutput("A.trig.before", 32'(wcA - baseA), 32'd0);
    applyStimulus(0, 0, 1, 0, 1, 0);
    checkOutput("A.trig.wr_en", 32'(ifA.wr_en), 32'd1);
    checkOutput("A.trig.wr_addr", 32'(ifA.wr_addr), 32'd0);
    checkOutput("A.trig.wr_data", ifA.wr_data, 32'h0000_0abc);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
`endif

    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
